// File: rtl/instruction_fetch.sv
// instruction_fetch: sequential instruction fetch unit (IDLE -> FETCH -> CAPTURE -> VALID).
// Issues one read per instruction to a synchronous-read instruction memory, holds the
// fetched word until downstream accepts it, and supports redirect (branch/jump) and halt.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               begin fetching from current PC (IDLE only)
//   halt                return to IDLE (highest priority)
//   redirect_valid/addr branch/jump request and target
//   instr_ready         downstream accepts instr this cycle
//   mem_read_data       instruction word, valid one cycle after the read strobe
//   mem_read_enable     read strobe (FETCH only)
//   mem_write_enable    constant 0
//   mem_address         current PC
//   instr/instr_pc      fetched word and the address it came from
//   instr_valid         instr holds a valid word
//   pc_overflow         sticky: PC ran past 14'h3FFF
//
// Build option: define FETCH_PC_WRAP_EN to let the PC wrap from 14'h3FFF to 14'h0000
// and keep fetching; otherwise the PC saturates, pc_overflow is set and fetching stops.
module instruction_fetch #(
    parameter logic [13:0] RESET_PC = 14'h2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        halt,
    input  logic        redirect_valid,
    input  logic [13:0] redirect_addr,
    input  logic        instr_ready,
    input  logic [26:0] mem_read_data,
    output logic        mem_read_enable,
    output logic        mem_write_enable,
    output logic [13:0] mem_address,
    output logic [26:0] instr,
    output logic        instr_valid,
    output logic [13:0] instr_pc,
    output logic        pc_overflow
);

    localparam int unsigned PC_W    = 14;
    localparam int unsigned INSTR_W = 27;
    localparam logic [PC_W-1:0] PC_MAX = 14'h3FFF;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_FETCH   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_VALID   = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    instr_pc_q, instr_pc_d;
    logic               overflow_q, overflow_d;
    logic               rd_en_q;
    logic               valid_q;

    // State and datapath registers; strobe/valid flops follow the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
            overflow_q <= 1'b0;
            rd_en_q    <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            overflow_q <= overflow_d;
            rd_en_q    <= (state_d == S_FETCH);
            valid_q    <= (state_d == S_VALID);
        end
    end

    // Next-state logic. Priority: halt > redirect > normal sequencing (incl. handshake).
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        overflow_d = overflow_q;

        if (halt) begin
            state_d = S_IDLE;
            if (redirect_valid) begin
                pc_d       = redirect_addr;
                overflow_d = 1'b0;
            end
        end else if (redirect_valid) begin
            // Any in-flight or held word is dropped simply by not entering VALID.
            pc_d       = redirect_addr;
            overflow_d = 1'b0;
            state_d    = (state_q == S_IDLE) ? S_IDLE : S_FETCH;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !overflow_q) begin
                        state_d = S_FETCH;
                    end
                end
                S_FETCH: begin
                    state_d = S_CAPTURE;
                end
                S_CAPTURE: begin
                    instr_d    = mem_read_data;
                    instr_pc_d = pc_q;
                    state_d    = S_VALID;
`ifdef FETCH_PC_WRAP_EN
                    pc_d = pc_q + PC_W'(1);
`else
                    // Saturate at the top of the address space and flag it.
                    if (pc_q == PC_MAX) begin
                        overflow_d = 1'b1;
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
`endif
                end
                S_VALID: begin
                    if (instr_ready) begin
                        state_d = overflow_q ? S_IDLE : S_FETCH;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign mem_read_enable  = rd_en_q;
    assign mem_write_enable = 1'b0;
    assign mem_address      = pc_q;
    assign instr            = instr_q;
    assign instr_pc         = instr_pc_q;
    assign instr_valid      = valid_q;
    assign pc_overflow      = overflow_q;

endmodule
